// File: rtl/shift_right_sipo_rx.sv
// Serial-in/parallel-out receiver: frames a bit_en-qualified serial stream into a
// WIDTH-bit word and hands it off with a valid/ack handshake and overrun flag.
module shift_right_sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_en,
    input  logic             serial_data_in,
    input  logic             data_ack,
    output logic [WIDTH-1:0] parallel_data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_restart,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pdo_q, pdo_d;
    logic             valid_q, valid_d;
    logic             restart_q, restart_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        if (LSB_FIRST) begin
            shifted = {serial_data_in, sreg_q[WIDTH-1:1]};
        end else begin
            shifted = {sreg_q[WIDTH-2:0], serial_data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            pdo_q     <= '0;
            valid_q   <= 1'b0;
            restart_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            pdo_q     <= pdo_d;
            valid_q   <= valid_d;
            restart_q <= restart_d;
            overrun_q <= overrun_d;
        end
    end

    // Ack is applied first so a completion in the same cycle re-asserts valid.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        pdo_d     = pdo_q;
        valid_d   = valid_q;
        restart_d = 1'b0;
        overrun_d = overrun_q;

        if (valid_q && data_ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end
            end
            RECV: begin
                if (start) begin
                    cnt_d     = '0;
                    sreg_d    = '0;
                    restart_d = 1'b1;
                end else if (bit_en) begin
                    sreg_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        pdo_d   = shifted;
                        valid_d = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (valid_q && !data_ack) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign parallel_data_out = pdo_q;
    assign data_valid        = valid_q;
    assign busy              = (state_q == RECV);
    assign frame_restart     = restart_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_shift_right_sipo_rx.sv
// Self-checking bench for shift_right_sipo_rx: LSB-first and MSB-first instances,
// expected words queued at stimulus time and checked when the word appears.
module tb_shift_right_sipo_rx;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic bit_en = 1'b0;
    logic sdi = 1'b0;
    logic ack = 1'b0;
    logic sel = 1'b0;

    logic st_a, en_a, ack_a, st_m, en_m, ack_m;
    logic [W-1:0] pdo_a, pdo_m;
    logic dv_a, busy_a, fr_a, ov_a;
    logic dv_m, busy_m, fr_m, ov_m;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    assign st_a  = start  & ~sel;
    assign en_a  = bit_en & ~sel;
    assign ack_a = ack    & ~sel;
    assign st_m  = start  & sel;
    assign en_m  = bit_en & sel;
    assign ack_m = ack    & sel;

    shift_right_sipo_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .start(st_a), .bit_en(en_a),
        .serial_data_in(sdi), .data_ack(ack_a),
        .parallel_data_out(pdo_a), .data_valid(dv_a), .busy(busy_a),
        .frame_restart(fr_a), .overrun(ov_a)
    );

    shift_right_sipo_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .start(st_m), .bit_en(en_m),
        .serial_data_in(sdi), .data_ack(ack_m),
        .parallel_data_out(pdo_m), .data_valid(dv_m), .busy(busy_m),
        .frame_restart(fr_m), .overrun(ov_m)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] g_pdo();
        return sel ? pdo_m : pdo_a;
    endfunction
    function automatic logic g_dv();
        return sel ? dv_m : dv_a;
    endfunction
    function automatic logic g_busy();
        return sel ? busy_m : busy_a;
    endfunction
    function automatic logic g_fr();
        return sel ? fr_m : fr_a;
    endfunction
    function automatic logic g_ov();
        return sel ? ov_m : ov_a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic en, input logic d, input logic a);
        start  = st;
        bit_en = en;
        sdi    = d;
        ack    = a;
        tick();
        start  = 1'b0;
        bit_en = 1'b0;
        ack    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pdo"},  32'(g_pdo()),  32'h0);
        check_eq({tag, "_dv"},   32'(g_dv()),   32'h0);
        check_eq({tag, "_busy"}, 32'(g_busy()), 32'h0);
        check_eq({tag, "_fr"},   32'(g_fr()),   32'h0);
        check_eq({tag, "_ov"},   32'(g_ov()),   32'h0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero(tag);
    endtask

    task automatic ack_word(input string tag);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq({tag, "_ackclr"}, 32'(g_dv()), 32'h0);
    endtask

    // stream[0] is the first bit on the wire; exp_fr is the restart pulse expected after start
    task automatic send_frame(input string tag, input logic [W-1:0] stream, input int gap_at,
                              input int gap_len, input logic ack_last, input logic exp_fr,
                              input logic exp_ov);
        logic [W-1:0] w;
        logic [W-1:0] got_exp;
        for (int i = 0; i < W; i++) begin
            if (sel) w[W-1-i] = stream[i];
            else     w[i]     = stream[i];
        end
        exp_q.push_back(w);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq({tag, "_busy_start"}, 32'(g_busy()), 32'h1);
        check_eq({tag, "_fr_start"},   32'(g_fr()),   32'(exp_fr));
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b0, 1'b0, ~stream[i], 1'b0);
                    check_eq({tag, "_busy_gap"}, 32'(g_busy()), 32'h1);
                end
            end
            drive(1'b0, 1'b1, stream[i], (i == W - 1) ? ack_last : 1'b0);
            if (i == 0) check_eq({tag, "_fr_clear"}, 32'(g_fr()), 32'h0);
            if (i < W - 1) check_eq({tag, "_busy_bit"}, 32'(g_busy()), 32'h1);
        end
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            got_exp = exp_q.pop_front();
            check_eq({tag, "_pdo"},  32'(g_pdo()),  32'(got_exp));
        end
        check_eq({tag, "_dv"},   32'(g_dv()),   32'h1);
        check_eq({tag, "_busy"}, 32'(g_busy()), 32'h0);
        check_eq({tag, "_ov"},   32'(g_ov()),   32'(exp_ov));
    endtask

    initial begin
        logic [W-1:0] piso;
        logic [W-1:0] stream;

        tick();
        reset = 1'b0;
        check_all_zero("reset_lsb");
        sel = 1'b1;
        check_all_zero("reset_msb");
        sel = 1'b0;

        // bit_en without start is ignored
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_all_zero("idle_biten");

        send_frame("basic", 4'b1101, -1, 0, 1'b0, 1'b0, 1'b0);
        ack_word("basic");

        send_frame("gap", 4'b1101, 2, 3, 1'b0, 1'b0, 1'b0);
        ack_word("gap");

        sel = 1'b1;
        send_frame("msb", 4'b0001, -1, 0, 1'b0, 1'b0, 1'b0);
        check_eq("msb_word_const", 32'(pdo_m), 32'h8);
        ack_word("msb");
        sel = 1'b0;

        // Restart mid-frame: two bits thrown away, then a clean frame
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("restart_no_dv", 32'(dv_a), 32'h0);
        send_frame("restart", 4'b0010, -1, 0, 1'b0, 1'b1, 1'b0);
        ack_word("restart");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("restart_single_dv", 32'(dv_a), 32'h0);
        end

        send_frame("ovr_a", 4'b0011, -1, 0, 1'b0, 1'b0, 1'b0);
        send_frame("ovr_b", 4'b1100, -1, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ovr_sticky", 32'(ov_a), 32'h1);
        do_reset("ovr_reset");

        send_frame("ackc_a", 4'b0011, -1, 0, 1'b0, 1'b0, 1'b0);
        send_frame("ackc_b", 4'b1100, -1, 0, 1'b1, 1'b0, 1'b0);
        ack_word("ackc");

        // Reset wins mid-frame; partial word is discarded
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        do_reset("midreset");
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("midreset_idle", 32'(busy_a), 32'h0);
        send_frame("after_reset", 4'b0110, -1, 0, 1'b0, 1'b0, 1'b0);
        ack_word("after_reset");

        // Right-shift PISO model: emits bit 0 first, shifting toward LSB
        piso = 4'b1010;
        for (int i = 0; i < W; i++) begin
            stream[i] = piso[0];
            piso = piso >> 1;
        end
        send_frame("loopback", stream, 1, 2, 1'b0, 1'b0, 1'b0);
        check_eq("loopback_word_const", 32'(pdo_a), 32'hA);
        ack_word("loopback");

        check_eq("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_sipo_rx.md
Name: shift_right_sipo_rx

Overview:
- Serial-in/parallel-out receiver; the receive end of the team's right-shift PISO link.
- Deserialises a framed serial bitstream (LSB-first by default) into a WIDTH-bit word.
- Presents the word with a valid/ack handshake and flags restarts and overruns.
- Sits between the serial link and the consuming parallel logic.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- LSB_FIRST, 1, 1 = first received bit lands in bit 0 (matches right-shift PISO); 0 = first bit lands in bit WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame start; arms reception; serial_data_in ignored in that cycle.
- bit_en  input  1  qualifies serial_data_in as a valid bit this cycle.
- serial_data_in  input  1  serial data bit.
- data_ack  input  1  consumer accepts parallel_data_out.
- parallel_data_out  output  WIDTH  last completed word, registered.
- data_valid  output  1  word pending; held until acked.
- busy  output  1  high while in RECV.
- frame_restart  output  1  one-cycle pulse: start seen while in RECV.
- overrun  output  1  sticky: a word completed while the previous word was still un-acked.

Behaviour:
- Reset (sampled high at rising edge):
  - state=IDLE, shift register=0, bit_count=0.
  - parallel_data_out=0, data_valid=0, busy=0, frame_restart=0, overrun=0.
  - Reset wins over every other input, including mid-frame; a partial word is discarded and no data_valid is produced.
- Internals:
  - bit_count is $clog2(WIDTH+1) bits wide.
  - shift register is WIDTH bits wide.
- IDLE:
  - busy=0.
  - start=1: go to RECV; bit_count=0; shift register cleared.
  - bit_en without a preceding start: ignored.
- RECV:
  - busy=1.
  - bit_en=1 and LSB_FIRST=1: sreg <= {serial_data_in, sreg[WIDTH-1:1]}.
  - bit_en=1 and LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], serial_data_in}.
  - bit_en=1 also increments bit_count.
  - bit_en=0: hold all state. Gaps of any length are legal.
  - Completion (bit_en=1 with bit_count==WIDTH-1):
    - At that same edge, parallel_data_out <= assembled word including the current bit; data_valid <= 1; state <= IDLE.
    - Latency: word visible one edge after the last bit is sampled.
  - start=1 in RECV (priority over bit_en):
    - bit_count <= 0; shift register cleared; stay in RECV.
    - frame_restart pulses high for exactly one cycle; the current bit is not captured.
- Handshake:
  - data_valid stays high until data_ack=1 is sampled; cleared at that edge.
  - data_ack while data_valid=0: no effect.
  - Completion with data_valid=1 and data_ack=0: new word overwrites parallel_data_out; data_valid stays 1; overrun <= 1.
  - Completion in the same cycle as data_ack with data_valid=1: old word consumed; new word loaded; data_valid stays 1; no overrun.
- overrun is cleared only by reset.
- parallel_data_out changes only at completion or reset.
- start in IDLE and completion cannot coincide. start in the completion cycle is handled as the restart case; the word does not complete.

Test Plan:
- WIDTH=4, LSB_FIRST=1: reset, start, then bit_en=1 with bits 1,0,1,1 on consecutive cycles -> parallel_data_out=4'b1101, data_valid=1 one edge after 4th bit, busy drops same edge; data_ack -> data_valid=0 next edge.
- Same stream with bit_en low for 3 cycles between bits 2 and 3 -> identical 4'b1101, no extra valid, busy held through gap.
- LSB_FIRST=0, bits 1,0,0,0 -> parallel_data_out=4'b1000.
- Start, bits 1,1, start again, then bits 0,1,0,0 -> frame_restart one-cycle pulse at second start, result 4'b0010, only one data_valid.
- Two back-to-back frames (0x3 then 0xC), no ack -> parallel_data_out=0xC, data_valid=1, overrun=1. Repeat with data_ack in the second completion cycle -> overrun stays 0.
- Reset asserted after 2 of 4 bits -> all outputs 0, IDLE. Subsequent full frame 4'b0110 received correctly. Loopback from the PISO (load 4'b1010) yields 4'b1010.
